// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and encodings for the run controller.
// Optional feature macro used by run_ctrl: RUN_CTRL_LIMIT_EN (cycle-limit timeout).
package run_ctrl_pkg;

    // Run-controller states; the encoding is also the status-word state field
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // rd_sel encodings
    localparam logic [1:0] SEL_CYCLES = 2'd0;
    localparam logic [1:0] SEL_INSTR  = 2'd1;
    localparam logic [1:0] SEL_STALL  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // Status-word bit positions
    localparam int STATUS_STATE_LSB   = 0;
    localparam int STATUS_STATE_MSB   = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;

    // A run is active (counting) in RUN and DRAIN
    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter with synchronous clear and saturating increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next value: clear wins, otherwise increment unless already at all-ones
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = {W{1'b0}};
        end else if (inc && (value_q != MAX_VAL)) begin
            value_d = value_q + W'(1'b1);
        end else begin
            value_d = value_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= {W{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: program-run sequencer with cycle / retired-instruction / stall
// counters and a one-cycle-latency counter read port.
// Optional feature macro: RUN_CTRL_LIMIT_EN enables the cycle-limit timeout;
// without it a run ends only on halt and timeout stays 0.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CW           = 32,
    parameter int CYCLE_LIMIT  = 100000,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_halt,
    input  logic          w_v,
    input  logic          stall,
    input  logic          rd_req,
    input  logic [1:0]    rd_sel,
    output logic          rd_ack,
    output logic [CW-1:0] rd_data,
    output logic          running,
    output logic          done,
    output logic          timeout
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          timeout_q, timeout_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          rd_ack_q, rd_ack_d;
    logic [CW-1:0] rd_data_q, rd_data_d;

    logic          clr_s;
    logic          limit_hit_s;
    logic          cyc_inc_s, ins_inc_s, stl_inc_s;
    logic [CW-1:0] cyc_cnt_s, ins_cnt_s, stl_cnt_s;

`ifdef RUN_CTRL_LIMIT_EN
    // Compared at 64 bits so a limit beyond the counter range simply never fires
    localparam logic [63:0] LIMIT_M1 = 64'(CYCLE_LIMIT - 1);
    assign limit_hit_s = (64'(cyc_cnt_s) == LIMIT_M1);
`else
    assign limit_hit_s = 1'b0;
`endif

    // Counter increment qualification by state
    assign cyc_inc_s = is_active(state_q);
    assign ins_inc_s = is_active(state_q) && w_v;
    assign stl_inc_s = (state_q == ST_RUN) && stall && !w_v;

    sat_counter #(.W(CW)) u_cyc_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(cyc_inc_s), .value(cyc_cnt_s)
    );
    sat_counter #(.W(CW)) u_ins_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(ins_inc_s), .value(ins_cnt_s)
    );
    sat_counter #(.W(CW)) u_stl_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(stl_inc_s), .value(stl_cnt_s)
    );

    // Next-state logic: run sequencing, drain countdown, timeout flag
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;
        clr_s     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    clr_s     = 1'b1;
                    timeout_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                // Halt has priority over the limit in the same cycle
                if (is_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (limit_hit_s) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == {DW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values: status flags from next state, read data from current counters
    always_comb begin
        running_d = is_active(state_d);
        done_d    = (state_d == ST_DONE);
        rd_ack_d  = rd_req;
        rd_data_d = {CW{1'b0}};
        if (rd_req) begin
            case (rd_sel)
                SEL_CYCLES: rd_data_d = cyc_cnt_s;
                SEL_INSTR:  rd_data_d = ins_cnt_s;
                SEL_STALL:  rd_data_d = stl_cnt_s;
                SEL_STATUS: begin
                    rd_data_d[STATUS_STATE_MSB:STATUS_STATE_LSB] = state_q;
                    rd_data_d[STATUS_TIMEOUT_BIT]                = timeout_q;
                end
                default:    rd_data_d = {CW{1'b0}};
            endcase
        end else begin
            rd_data_d = {CW{1'b0}};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            drain_q   <= {DW{1'b0}};
            timeout_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
            running_q <= running_d;
            done_q    <= done_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: table-driven bench with a read-port scoreboard for run_ctrl.
// Honours RUN_CTRL_LIMIT_EN when it is defined for the build.
module tb_run_ctrl;

    logic        clk, rst_n;
    logic        start, is_halt, w_v, stall, rd_req;
    logic [1:0]  rd_sel;
    logic        rd_ack, running, done, timeout;
    logic [31:0] rd_data;

    logic        s_start, s_halt, s_wv, s_stall, s_req;
    logic [1:0]  s_sel;
    logic        s_ack, s_running, s_done, s_timeout;
    logic [3:0]  s_data;

    run_ctrl #(.CW(32), .CYCLE_LIMIT(100), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_halt(is_halt), .w_v(w_v),
        .stall(stall), .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack),
        .rd_data(rd_data), .running(running), .done(done), .timeout(timeout)
    );

    run_ctrl #(.CW(4), .CYCLE_LIMIT(100000), .DRAIN_CYCLES(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .is_halt(s_halt), .w_v(s_wv),
        .stall(s_stall), .rd_req(s_req), .rd_sel(s_sel), .rd_ack(s_ack),
        .rd_data(s_data), .running(s_running), .done(s_done), .timeout(s_timeout)
    );

    typedef struct {
        logic        start, halt, wv, stl, req;
        logic [1:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_run, exp_done;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;

    sb_t  sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic hl, input logic wv, input logic sl,
                                input logic rq, input logic [1:0] se, input logic [31:0] er,
                                input logic xr, input logic xd);
        vec_t v;
        v.start = st; v.halt = hl; v.wv = wv; v.stl = sl; v.req = rq;
        v.sel = se; v.exp_rd = er; v.exp_run = xr; v.exp_done = xd;
        return v;
    endfunction

    // Drive one cycle of inputs, queue any read expectation, check flags after the edge
    task automatic step(input vec_t v, input string tag);
        sb_t e;
        start = v.start; is_halt = v.halt; w_v = v.wv; stall = v.stl;
        rd_req = v.req; rd_sel = v.sel;
        if (v.req) begin
            e.data = v.exp_rd;
            e.cyc  = cyc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({tag, " running"}, 32'(running), 32'(v.exp_run));
        chk({tag, " done"}, 32'(done), 32'(v.exp_done));
    endtask

    // Read-port scoreboard: ack exactly one cycle after a request, data zero otherwise
    initial forever begin
        sb_t e;
        @(negedge clk);
        if (rst_n) begin
            if (rd_ack) begin
                if (sbq.size() == 0) begin
                    chk("unexpected ack", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("ack latency", 32'(e.cyc), 32'(cyc - 1));
                    chk("rd_data", rd_data, e.data);
                end
            end else begin
                chk("rd_data idle", rd_data, 32'd0);
                if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    chk("missing ack", 32'(rd_ack), 32'd1);
                end
            end
        end
    end

    // Assert reset mid-cycle and check every output drops at once
    task automatic do_reset(input string tag);
        start = 1'b0; is_halt = 1'b0; w_v = 1'b0; stall = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;
        rst_n = 1'b0;
        #1;
        chk({tag, " rst running"}, 32'(running), 32'd0);
        chk({tag, " rst done"}, 32'(done), 32'd0);
        chk({tag, " rst timeout"}, 32'(timeout), 32'd0);
        chk({tag, " rst rd_ack"}, 32'(rd_ack), 32'd0);
        chk({tag, " rst rd_data"}, rd_data, 32'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t idle_done;

        rst_n = 1'b1;
        start = 1'b0; is_halt = 1'b0; w_v = 1'b0; stall = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;
        s_start = 1'b0; s_halt = 1'b0; s_wv = 1'b0; s_stall = 1'b0; s_req = 1'b0; s_sel = 2'd0;
        #3;
        do_reset("init");

        // Main run: start, 10 retirements, halt, 4-cycle drain, reads
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0)); // start ignored in RUN
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd4, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd5, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0)); // stall with retire
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0)); // halt
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0)); // retire in drain
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0)); // start ignored
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0)); // stall in drain
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1)); // done
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd15, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'd11, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd3, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd15, 1'b1, 1'b0)); // restart + pre-clear read
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd5, 1'b1, 1'b0)); // ack cut by reset
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("tbl%0d", i));

        // Reset while running with an ack in flight
        do_reset("midrun");
        step(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0), "idle0");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'd0, 1'b0, 1'b0), "idle1");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'd0, 1'b0, 1'b0), "idle2");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd0, 1'b0, 1'b0), "idle3");

        // Stall counting plus back-to-back cycle reads
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "st start");
        step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0, 1'b1, 1'b0), "st1");
        step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'd1, 1'b1, 1'b0), "st2");
        step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'd2, 1'b1, 1'b0), "st3");
        step(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "st4");
        step(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "st5");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "st halt");
        for (int i = 0; i < 3; i++)
            step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "st drain");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1), "st done");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'd3, 1'b0, 1'b1), "st rd2");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'd2, 1'b0, 1'b1), "st rd1");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1), "st idle");

        // Cycle limit with no halt
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "lim start");
        for (int i = 1; i < 100; i++)
            step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "lim run");
`ifdef RUN_CTRL_LIMIT_EN
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1), "lim hit");
        chk("lim timeout", 32'(timeout), 32'd1);
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd100, 1'b0, 1'b1), "lim rd0");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd7, 1'b0, 1'b1), "lim rd3");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "lim restart");
        chk("lim timeout cleared", 32'(timeout), 32'd0);
`else
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "nolim run");
        chk("nolim timeout", 32'(timeout), 32'd0);
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd1, 1'b1, 1'b0), "nolim rd3");
`endif
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "lim idle");

        // Halt in the same cycle the limit is reached: halt wins
        do_reset("hw");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "hw start");
        for (int i = 1; i < 100; i++)
            step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "hw run");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "hw halt");
        chk("hw timeout", 32'(timeout), 32'd0);
        for (int i = 0; i < 3; i++)
            step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0), "hw drain");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1), "hw done");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd3, 1'b0, 1'b1), "hw rd3");

        // Narrow instance: saturation at 15 and a single drain cycle
        idle_done = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        s_start = 1'b1;
        step(idle_done, "sm start");
        s_start = 1'b0;
        s_wv = 1'b1;
        for (int i = 0; i < 20; i++)
            step(idle_done, "sm run");
        chk("sm running", 32'(s_running), 32'd1);
        s_wv = 1'b0;
        s_halt = 1'b1;
        step(idle_done, "sm halt");
        chk("sm drain running", 32'(s_running), 32'd1);
        chk("sm drain done", 32'(s_done), 32'd0);
        s_halt = 1'b0;
        step(idle_done, "sm drain");
        chk("sm done", 32'(s_done), 32'd1);
        s_req = 1'b1;
        s_sel = 2'd1;
        step(idle_done, "sm rd1");
        chk("sm ack", 32'(s_ack), 32'd1);
        chk("sm instr sat", 32'(s_data), 32'd15);
        s_sel = 2'd0;
        step(idle_done, "sm rd0");
        chk("sm cycle sat", 32'(s_data), 32'd15);
        s_sel = 2'd3;
        step(idle_done, "sm rd3");
        chk("sm status", 32'(s_data), 32'd3);
        s_req = 1'b0;
        step(idle_done, "sm idle");
        chk("sm ack low", 32'(s_ack), 32'd0);
        chk("sm data low", 32'(s_data), 32'd0);
        chk("sm timeout", 32'(s_timeout), 32'd0);

        chk("scoreboard empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller and performance-counter block for the single-clock CPU core. Sequences a program run: start, execution, halt drain, completion or cycle-limit timeout. Accumulates cycle, retired-instruction and stall counts and serves them to the testbench or debug logic over a one-request/one-ack read port. Sits beside the core's writeback stage, sampling `is_halt`, `w_v` and `stall`.

## Interface
- `CW`, 32: width of all counters and of `rd_data`.
- `CYCLE_LIMIT`, 100000: cycle budget per run. Used only with `RUN_CTRL_LIMIT_EN`.
- `DRAIN_CYCLES`, 4: cycles spent in DRAIN after halt, so in-flight retirements are still counted. Must be ≥1.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: level-sampled request to begin a run.
- `is_halt` in 1: halt instruction reached writeback.
- `w_v` in 1: one instruction retired this cycle.
- `stall` in 1: core pipeline stalled this cycle.
- `rd_req` in 1: counter read request.
- `rd_sel` in 2: 0 = cycles, 1 = instructions, 2 = stall cycles, 3 = status.
- `rd_ack` out 1: one-cycle pulse; `rd_data` is valid in that cycle.
- `rd_data` out CW: selected value.
- `running` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.
- `timeout` out 1: the last run ended on the cycle limit. Sticky until the next start.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN: entered from IDLE or DONE when `start`=1. Entering RUN clears all counters and `timeout`.
  - DRAIN: entered from RUN when `is_halt`=1.
  - DONE: entered from DRAIN when its down-counter expires. The drain counter loads `DRAIN_CYCLES-1` on entry, so DRAIN lasts exactly `DRAIN_CYCLES` cycles.
- Timeout path (`RUN_CTRL_LIMIT_EN` only): in RUN, when the cycle counter equals `CYCLE_LIMIT-1` and `is_halt`=0, go to DONE and set `timeout`.
- Cycle counter: +1 every cycle in RUN or DRAIN.
- Instruction counter: +1 when `w_v`=1 in RUN or DRAIN.
- Stall counter: +1 when `stall`=1 and `w_v`=0 in RUN.
- Counters saturate at all-ones; they never wrap. They hold their values in IDLE and DONE.
- Input qualification:
  - `start` is ignored in RUN and DRAIN.
  - `is_halt` is ignored outside RUN.
  - `w_v` and `stall` are ignored in IDLE and DONE.
- Read port:
  - `rd_req` is accepted in any state, including back-to-back cycles.
  - `rd_sel` is captured with the request; `rd_ack` and `rd_data` follow one cycle later.
  - The value returned is the counter value registered at the request edge, before that edge's increment.
  - Status word: bits [1:0] state (IDLE=0, RUN=1, DRAIN=2, DONE=3), bit 2 `timeout`, remaining bits zero.
  - `rd_data` is zero whenever `rd_ack`=0.
- Simultaneous events:
  - `is_halt` and limit-reached in the same cycle: halt wins; go to DRAIN, `timeout` stays 0.
  - `start` in DONE together with `rd_req`: the read returns the pre-clear value.

## Timing
- All outputs are registered.
- Reset values: all counters 0, state IDLE, `running`=0, `done`=0, `timeout`=0, `rd_ack`=0, `rd_data`=0.
- Asserting `rst_n` mid-run forces all of the above immediately, with no drain.
- `start` sampled at edge N: `running`=1 after edge N, and the cycle counter reads 1 after edge N+1.
- `is_halt` at edge N: DRAIN after N; `done`=1 after edge N+`DRAIN_CYCLES`.
- Read latency is exactly 1 cycle. There is no backpressure.

## Configuration
- `RUN_CTRL_LIMIT_EN` defined: cycle-limit timeout path is present, and `timeout` can assert.
- Not defined: no limit comparator. A run ends only on halt, and `timeout` is tied to 0. Status bit 2 then reads 0.

## Structure
- Shared package `run_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE, 2 bits);
  - the `rd_sel` encodings;
  - the status-word bit positions.
- Sub-module `sat_counter`, parameterised by width, with clear, increment and saturation. It is instantiated three times.

## Test plan
- Reset, then `start`, 10 cycles with `w_v`=1, then `is_halt`, with `DRAIN_CYCLES`=4 → `done` asserts 4 cycles after halt. Read sel 0 → 15; sel 1 → 10 plus any `w_v` pulses during drain.
- With `RUN_CTRL_LIMIT_EN` and `CYCLE_LIMIT`=100, no halt → DONE after cycle count 100, `timeout`=1. Status word reads 0x7.
- `is_halt` on the same cycle the limit is reached → DRAIN entered, `timeout`=0.
- `stall`=1 for 5 cycles, 2 of them with `w_v`=1 → stall counter reads 3.
- `rst_n` pulled low mid-RUN → all outputs 0 at once, state IDLE. `start` ignored during RUN, then honoured in DONE, clears counters.
- `CW`=4: 20 retirements → instruction counter holds 15. Back-to-back reads of sel 0 return consecutive values with 1-cycle ack.
